// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART blocks.
//   PAR_NONE/PAR_EVEN/PAR_ODD : parity mode encodings for the PARITY parameter
//   rx_state_e                : receiver FSM state encoding
//   calc_div()                : clocks per oversample tick, floor(clk/(baud*os))
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    return clk_hz / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receive-side bundle from the UART receiver to its consumer.
//   DATA       : last received payload, held until the next frame completes
//   VALID      : one-cycle strobe, DATA and the error flags were just updated
//   PARITY_ERR : parity mismatch on the delivered frame
//   FRAME_ERR  : a stop bit was sampled low on the delivered frame
//   BUSY       : receiver is not idle
// master = receiver (drives), slave = consumer.
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] DATA;
  logic                 VALID;
  logic                 PARITY_ERR;
  logic                 FRAME_ERR;
  logic                 BUSY;

  modport master (output DATA, VALID, PARITY_ERR, FRAME_ERR, BUSY);
  modport slave  (input  DATA, VALID, PARITY_ERR, FRAME_ERR, BUSY);
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   tick  : one-cycle pulse, period DIV clocks (constant high when DIV == 1)
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  always_comb begin
    wrap  = (cnt_q == CW'(DIV - 1));
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = wrap;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver.
//   CLK50MHz : system clock, rising edge
//   RESET_N  : asynchronous active-low reset
//   RX       : serial line, asynchronous, idle high
//   rx_if    : master side of uart_rx_param_if (DATA, VALID, PARITY_ERR,
//              FRAME_ERR, BUSY)
// Start-bit glitch rejection at the start midpoint, mid-bit sampling of
// data/parity/stop, and a WAIT_HIGH state after a framing error so a held-low
// line (break) cannot launch a new frame until it returns high.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic            CLK50MHz,
  input  logic            RESET_N,
  input  logic            RX,
  uart_rx_param_if.master rx_if
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam int unsigned IW  = $clog2(DATA_BITS);

  localparam logic [SW-1:0] HALF_M1   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_M1   = SW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  if (DIV == 0) begin : g_err_div
    $error("uart_rx_param: CLK_HZ/(BAUD*OVERSAMPLE) must be at least 1");
  end
  if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_err_os
    $error("uart_rx_param: OVERSAMPLE must be even and >= 4");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_err_db
    $error("uart_rx_param: DATA_BITS must be in 5..9");
  end
  if (PARITY > PAR_ODD) begin : g_err_par
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_err_sb
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end

  logic tick;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk   (CLK50MHz),
    .rst_n (RESET_N),
    .tick  (tick)
  );

  // Two-flop synchroniser; both stages reset to the idle (high) level.
  logic rx_meta_q, rx_meta_d;
  logic rx_s_q, rx_s_d;

  rx_state_e            state_q, state_d;
  logic [SW-1:0]        samp_cnt_q, samp_cnt_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 frame_ferr;

  always_comb begin
    rx_meta_d = RX;
    rx_s_d    = rx_meta_q;
  end

  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    data_d     = data_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    valid_d    = 1'b0;
    frame_ferr = ferr_q | ~rx_s_q;

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            samp_cnt_d = '0;
            state_d    = ST_START;
          end
        end

        ST_START: begin
          if (samp_cnt_q == HALF_M1) begin
            if (rx_s_q) begin
              state_d = ST_IDLE;
            end else begin
              // From here every later sample lands a full bit later, i.e.
              // on the midpoint of the next bit.
              samp_cnt_d = '0;
              bit_idx_d  = '0;
              perr_d     = 1'b0;
              ferr_d     = 1'b0;
              state_d    = ST_DATA;
            end
          end else begin
            samp_cnt_d = samp_cnt_q + SW'(1);
          end
        end

        ST_DATA: begin
          if (samp_cnt_q == FULL_M1) begin
            shreg_d[bit_idx_q] = rx_s_q;
            samp_cnt_d         = '0;
            if (bit_idx_q == LAST_BIT) begin
              bit_idx_d = '0;
              state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx_d = bit_idx_q + IW'(1);
            end
          end else begin
            samp_cnt_d = samp_cnt_q + SW'(1);
          end
        end

        ST_PARITY: begin
          if (samp_cnt_q == FULL_M1) begin
            perr_d     = (PARITY == PAR_ODD) ? ~^{shreg_q, rx_s_q}
                                             :  ^{shreg_q, rx_s_q};
            samp_cnt_d = '0;
            state_d    = ST_STOP;
          end else begin
            samp_cnt_d = samp_cnt_q + SW'(1);
          end
        end

        ST_STOP: begin
          if (samp_cnt_q == FULL_M1) begin
            samp_cnt_d = '0;
            ferr_d     = frame_ferr;
            if (bit_idx_q == LAST_STOP) begin
              // Outputs are registered here, so VALID appears on the clock
              // after the final stop-bit sample.
              bit_idx_d  = '0;
              data_d     = shreg_q;
              perr_out_d = perr_q;
              ferr_out_d = frame_ferr;
              valid_d    = 1'b1;
              state_d    = frame_ferr ? ST_WAIT_HIGH : ST_IDLE;
            end else begin
              bit_idx_d = bit_idx_q + IW'(1);
            end
          end else begin
            samp_cnt_d = samp_cnt_q + SW'(1);
          end
        end

        ST_WAIT_HIGH: begin
          if (rx_s_q) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK50MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= ST_IDLE;
      samp_cnt_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_s_q     <= rx_s_d;
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
    end
  end

  assign rx_if.DATA       = data_q;
  assign rx_if.VALID      = valid_q;
  assign rx_if.PARITY_ERR = perr_out_q;
  assign rx_if.FRAME_ERR  = ferr_out_q;
  assign rx_if.BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances (8N1, 8E1, 7N2) sharing
// clock and reset, each with its own serial line and interface.
module tb_uart_rx_param;

  localparam int unsigned CLK_HZ   = 3200000;
  localparam int unsigned BAUD     = 100000;
  localparam int unsigned OS       = 16;
  localparam int          BIT_CLKS = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  logic rx_c = 1'b1;

  always #5 clk = ~clk;

  uart_rx_param_if #(.DATA_BITS(8)) if_a ();
  uart_rx_param_if #(.DATA_BITS(8)) if_b ();
  uart_rx_param_if #(.DATA_BITS(7)) if_c ();

  uart_rx_param #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut_a (
    .CLK50MHz(clk), .RESET_N(rst_n), .RX(rx_a), .rx_if(if_a)
  );

  uart_rx_param #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)
  ) dut_b (
    .CLK50MHz(clk), .RESET_N(rst_n), .RX(rx_b), .rx_if(if_b)
  );

  uart_rx_param #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)
  ) dut_c (
    .CLK50MHz(clk), .RESET_N(rst_n), .RX(rx_c), .rx_if(if_c)
  );

  int tests = 0;
  int fails = 0;
  int va = 0;
  int vb = 0;
  int vc = 0;
  int cyc = 0;
  int vc_t0 = 0;
  int vc_t1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // VALID high-cycle counters: a strobe longer than one clock shows up as
  // an extra count.
  always @(negedge clk) begin
    if (if_a.VALID === 1'b1) va <= va + 1;
    if (if_b.VALID === 1'b1) vb <= vb + 1;
    if (if_c.VALID === 1'b1) begin
      vc    <= vc + 1;
      vc_t0 <= vc_t1;
      vc_t1 <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int ch, input logic v);
    case (ch)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // Shifts bits[0..n-1] out LSB first, one bit per BIT_CLKS, then leaves
  // the line at 'tail'.
  task automatic send(input int ch, input logic [15:0] bits, input int n, input logic tail);
    for (int i = 0; i < n; i++) begin
      set_rx(ch, bits[i]);
      repeat (BIT_CLKS) @(negedge clk);
    end
    set_rx(ch, tail);
  endtask

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data",  if_a.DATA, 32'h0);
    chk("rst_valid", if_a.VALID, 32'h0);
    chk("rst_perr",  if_a.PARITY_ERR, 32'h0);
    chk("rst_ferr",  if_a.FRAME_ERR, 32'h0);
    chk("rst_busy",  if_a.BUSY, 32'h0);
    rst_n = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);

    // 1: 8N1 0xA5
    send(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    chk("t1_vcount", va, 32'd1);
    chk("t1_data",   if_a.DATA, 32'hA5);
    chk("t1_perr",   if_a.PARITY_ERR, 32'h0);
    chk("t1_ferr",   if_a.FRAME_ERR, 32'h0);
    chk("t1_busy",   if_a.BUSY, 32'h0);

    // 2: 10-clock low glitch
    set_rx(0, 1'b0);
    repeat (8) @(negedge clk);
    chk("t2_busy_start", if_a.BUSY, 32'h1);
    repeat (2) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("t2_vcount", va, 32'd1);
    chk("t2_data",   if_a.DATA, 32'hA5);
    chk("t2_busy",   if_a.BUSY, 32'h0);

    // 3: 8E1, 0x07 (three ones): parity bit 0 is wrong, 1 is right
    send(1, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    chk("t3a_vcount", vb, 32'd1);
    chk("t3a_data",   if_b.DATA, 32'h07);
    chk("t3a_perr",   if_b.PARITY_ERR, 32'h1);
    chk("t3a_ferr",   if_b.FRAME_ERR, 32'h0);
    send(1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    chk("t3b_vcount", vb, 32'd2);
    chk("t3b_data",   if_b.DATA, 32'h07);
    chk("t3b_perr",   if_b.PARITY_ERR, 32'h0);

    // 4: 0x3C with low stop bit, line held low 20 bits, then 0x55
    send(0, {6'b0, 1'b0, 8'h3C, 1'b0}, 10, 1'b0);
    chk("t4_vcount", va, 32'd2);
    chk("t4_data",   if_a.DATA, 32'h3C);
    chk("t4_ferr",   if_a.FRAME_ERR, 32'h1);
    chk("t4_perr",   if_a.PARITY_ERR, 32'h0);
    chk("t4_busy_wait", if_a.BUSY, 32'h1);
    repeat (20 * BIT_CLKS) @(negedge clk);
    chk("t4_vcount_low", va, 32'd2);
    chk("t4_busy_low",   if_a.BUSY, 32'h1);
    set_rx(0, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    chk("t4_busy_idle", if_a.BUSY, 32'h0);
    send(0, {6'b0, 1'b1, 8'h55, 1'b0}, 10, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    chk("t4_vcount_next", va, 32'd3);
    chk("t4_data_next",   if_a.DATA, 32'h55);
    chk("t4_ferr_next",   if_a.FRAME_ERR, 32'h0);

    // 5: reset in the middle of bit 4 of 0xF0 (bits 4..7 and stop are high)
    set_rx(0, 1'b0);
    repeat (5 * BIT_CLKS) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (BIT_CLKS / 2) @(negedge clk);
    chk("t5_busy_pre", if_a.BUSY, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t5_data",  if_a.DATA, 32'h0);
    chk("t5_valid", if_a.VALID, 32'h0);
    chk("t5_perr",  if_a.PARITY_ERR, 32'h0);
    chk("t5_ferr",  if_a.FRAME_ERR, 32'h0);
    chk("t5_busy",  if_a.BUSY, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (BIT_CLKS / 2 + 4 * BIT_CLKS) @(negedge clk);
    chk("t5_vcount", va, 32'd3);
    send(0, {6'b0, 1'b1, 8'h81, 1'b0}, 10, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    chk("t5_vcount_next", va, 32'd4);
    chk("t5_data_next",   if_a.DATA, 32'h81);
    chk("t5_ferr_next",   if_a.FRAME_ERR, 32'h0);

    // 6: 7N2 back-to-back 0x12, 0x7F
    send(2, {6'b0, 2'b11, 7'h12, 1'b0}, 10, 1'b1);
    chk("t6_vcount1", vc, 32'd1);
    chk("t6_data1",   if_c.DATA, 32'h12);
    send(2, {6'b0, 2'b11, 7'h7F, 1'b0}, 10, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    chk("t6_vcount2", vc, 32'd2);
    chk("t6_data2",   if_c.DATA, 32'h7F);
    chk("t6_ferr",    if_c.FRAME_ERR, 32'h0);
    chk("t6_spacing", vc_t1 - vc_t0, 32'd320);
    chk("t6_busy",    if_c.BUSY, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
